// File: rtl/dcache_ctrl_if.sv
// Backing-memory bus for dcache_ctrl: registered request side from the cache,
// single-cycle mem_ready completion pulse with fill data from the memory.
interface dcache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-through, no-write-allocate data cache for
// the MEM stage. One 32-bit word per line, byte loads/stores via lane select.
// Optional macro DCACHE_STATS_EN adds stat_hits / stat_misses counters.
module dcache_ctrl #(
    parameter int INDEX_W = 6,
    parameter int ADDR_W  = 32
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_byte,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              hit,
    output logic              stall,
    dcache_ctrl_if.master     mem
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       stat_hits,
    output logic [31:0]       stat_misses
`endif
);
    localparam int TAG_W = ADDR_W - INDEX_W - 2;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FILL = 2'd1, S_WRITE = 2'd2} state_e;

    state_e state_q, state_d;

    logic [LINES-1:0] valid_q, valid_d;
    logic [TAG_W-1:0] tag_arr  [LINES];
    logic [31:0]      data_arr [LINES];

    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [3:0]        mem_be_q, mem_be_d;

    // CPU-side lookup fields
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [1:0]         lane;
    logic [31:0]        line;
    logic [7:0]         lane_byte;

    // Outstanding-request fields; array updates use the latched request so a
    // changing cpu_addr can never redirect a fill or merge.
    logic [INDEX_W-1:0] r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [31:0]        r_line;
    logic               r_hit;
    logic [31:0]        merged;

    logic               line_we;
    logic [31:0]        line_wdata;

    assign idx    = cpu_addr[INDEX_W+1:2];
    assign tag    = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign lane   = cpu_addr[1:0];
    assign line   = data_arr[idx];

    assign r_idx  = mem_addr_q[INDEX_W+1:2];
    assign r_tag  = mem_addr_q[ADDR_W-1:INDEX_W+2];
    assign r_line = data_arr[r_idx];
    assign r_hit  = valid_q[r_idx] && (tag_arr[r_idx] == r_tag);

    assign hit = valid_q[idx] && (tag_arr[idx] == tag) && (cpu_read || cpu_write);

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_be    = mem_be_q;

    // Load data: whole line, or sign-extended little-endian byte lane
    always_comb begin
        lane_byte = line[{lane, 3'b000} +: 8];
        cpu_rdata = cpu_byte ? {{24{lane_byte[7]}}, lane_byte} : line;
    end

    // Store merge of the latched write data into the resident line
    always_comb begin
        merged = r_line;
        for (int b = 0; b < 4; b++) begin
            if (mem_be_q[b]) merged[8*b +: 8] = mem_wdata_q[8*b +: 8];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state: a write always goes to memory; only read misses fill
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_write)                state_d = S_WRITE;
                else if (cpu_read && !hit)    state_d = S_FILL;
            end
            S_FILL:  if (mem.mem_ready) state_d = S_IDLE;
            S_WRITE: if (mem.mem_ready) state_d = S_IDLE;
            default:                    state_d = S_IDLE;
        endcase
    end

    // Stall: a store retires in its mem_ready cycle; a load waits for the re-lookup
    always_comb begin
        stall = 1'b0;
        case (state_q)
            S_IDLE:  stall = cpu_write || (cpu_read && !hit);
            S_FILL:  stall = 1'b1;
            S_WRITE: stall = !mem.mem_ready;
            default: stall = 1'b0;
        endcase
    end

    // Request launch/retire and line/valid updates
    always_comb begin
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        valid_d     = valid_q;
        line_we     = 1'b0;
        line_wdata  = merged;
        case (state_q)
            S_IDLE: begin
                if (cpu_write) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = {cpu_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata_d = cpu_byte ? {4{cpu_wdata[7:0]}} : cpu_wdata;
                    mem_be_d    = cpu_byte ? (4'b0001 << lane) : 4'b1111;
                end else if (cpu_read && !hit) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {cpu_addr[ADDR_W-1:2], 2'b00};
                end
            end
            S_FILL: begin
                if (mem.mem_ready) begin
                    mem_req_d      = 1'b0;
                    line_we        = 1'b1;
                    line_wdata     = mem.mem_rdata;
                    valid_d[r_idx] = 1'b1;
                end
            end
            S_WRITE: begin
                if (mem.mem_ready) begin
                    mem_req_d = 1'b0;
                    line_we   = r_hit;
                end
            end
            default: ;
        endcase
    end

    // Request registers and valid bits; reset aborts any transfer in flight
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            valid_q     <= '0;
        end else begin
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            valid_q     <= valid_d;
        end
    end

    // Tag/data arrays: never reset, validity is tracked by valid_q alone
    always_ff @(posedge clk) begin
        if (line_we) begin
            data_arr[r_idx] <= line_wdata;
            tag_arr[r_idx]  <= r_tag;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    // Count retired read hits and fill entries; both wrap naturally
    always_comb begin
        stat_hits_d   = stat_hits_q +
                        {31'b0, (state_q == S_IDLE) && cpu_read && !cpu_write && hit};
        stat_misses_d = stat_misses_q +
                        {31'b0, (state_q == S_IDLE) && (state_d == S_FILL)};
    end

    // Statistics registers
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a transaction-level cache model predicts hit,
// stall length, request contents and load data; one compare process checks the
// DUT every cycle; literal checks pin the model to hand-computed values.
module tb_dcache_ctrl;
    localparam int LAT = 3;

    logic        clk, rst_b;
    logic        cpu_read, cpu_write, cpu_byte;
    logic [31:0] cpu_addr, cpu_wdata;
    wire  [31:0] cpu_rdata;
    wire         hit, stall;
`ifdef DCACHE_STATS_EN
    wire  [31:0] stat_hits, stat_misses;
`endif

    dcache_ctrl_if #(.ADDR_W(32)) mif ();

    dcache_ctrl #(.INDEX_W(6), .ADDR_W(32)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_byte  (cpu_byte),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .hit       (hit),
        .stall     (stall),
        .mem       (mif.master)
`ifdef DCACHE_STATS_EN
        ,
        .stat_hits   (stat_hits),
        .stat_misses (stat_misses)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // ---------------- backing memory ----------------
    logic [31:0] bmem [int unsigned];
    logic        force_ready = 1'b0;

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        if (bmem.exists(a)) return bmem[a];
        return {a[15:0], 16'hC0DE};
    endfunction

    // Memory responds with a one-cycle mem_ready after LAT waiting cycles
    initial begin
        int cnt;
        logic [31:0] w;
        cnt = 0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                cnt = 0;
                mif.mem_ready = 1'b0;
            end else if (force_ready) begin
                mif.mem_ready = 1'b1;
                mif.mem_rdata = 32'h1234_5678;
            end else if (mif.mem_req && !mif.mem_ready) begin
                if (cnt == LAT) begin
                    cnt = 0;
                    mif.mem_ready = 1'b1;
                    if (mif.mem_we) begin
                        w = mem_peek(mif.mem_addr);
                        for (int b = 0; b < 4; b++)
                            if (mif.mem_be[b]) w[8*b +: 8] = mif.mem_wdata[8*b +: 8];
                        bmem[mif.mem_addr] = w;
                    end else begin
                        mif.mem_rdata = mem_peek(mif.mem_addr);
                    end
                end else begin
                    cnt++;
                    mif.mem_ready = 1'b0;
                end
            end else begin
                cnt = 0;
                mif.mem_ready = 1'b0;
            end
        end
    end

    // ---------------- cache model ----------------
    logic        m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_data  [64];

    function automatic logic [31:0] extract(input logic [31:0] d, input logic byt, input logic [1:0] ln);
        logic [7:0] b;
        if (!byt) return d;
        b = 8'((d >> (8 * ln)) & 32'hFF);
        return b[7] ? {24'hFF_FFFF, b} : {24'h0, b};
    endfunction

    // Expectations shared with the compare process
    logic        chk_en = 1'b0, op_active = 1'b0;
    int          cur_cyc, exp_n, exp_req_last;
    logic        exp_hit, exp_we, exp_rd;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    // Observations recorded by the compare process
    int          stall_seen, req_seen;
    logic        prev_req = 1'b0;
    logic [31:0] last_addr, last_wdata, last_rdata;
    logic        last_we;
    logic [3:0]  last_be;

    // Single per-cycle compare against the model's expectations
    always @(negedge clk) begin
        #2;
        if (chk_en) begin
            if (!op_active) begin
                chk("idle_stall", 32'(stall), 32'd0);
                chk("idle_hit", 32'(hit), 32'd0);
                chk("idle_req", 32'(mif.mem_req), 32'd0);
            end else begin
                if (cur_cyc == 0) chk("first_hit", 32'(hit), 32'(exp_hit));
                chk("stall", 32'(stall), 32'(cur_cyc < exp_n));
                stall_seen += int'(stall);
                chk("mem_req", 32'(mif.mem_req), 32'(cur_cyc >= 1 && cur_cyc <= exp_req_last));
                if (cur_cyc >= 1 && cur_cyc <= exp_req_last) begin
                    chk("mem_addr", mif.mem_addr, exp_addr);
                    chk("mem_we", 32'(mif.mem_we), 32'(exp_we));
                    if (exp_we) begin
                        chk("mem_be", 32'(mif.mem_be), 32'(exp_be));
                        chk("mem_wdata", mif.mem_wdata, exp_wdata);
                    end
                end
                if (exp_rd && cur_cyc == exp_n) begin
                    chk("load_hit", 32'(hit), 32'd1);
                    chk("load_data", cpu_rdata, exp_rdata);
                    last_rdata = cpu_rdata;
                end
            end
        end
        if (mif.mem_req && !prev_req) begin
            req_seen++;
            last_addr  = mif.mem_addr;
            last_we    = mif.mem_we;
            last_be    = mif.mem_be;
            last_wdata = mif.mem_wdata;
        end
        prev_req = mif.mem_req;
    end

    // One CPU access held for the predicted stall length, then model update
    task automatic do_op(input logic rd, input logic wr, input logic byt,
                         input logic [31:0] addr, input logic [31:0] wd);
        logic [5:0]  ix;
        logic [31:0] aa, d;
        logic [3:0]  be;
        logic        mh;
        int          n;
        ix = addr[7:2];
        aa = {addr[31:2], 2'b00};
        mh = m_valid[ix] && (m_tag[ix] == addr[31:8]);
        be = byt ? (4'b0001 << addr[1:0]) : 4'b1111;
        d  = 32'h0;
        @(negedge clk);
        exp_hit = mh; exp_addr = aa; exp_rd = 1'b0; exp_we = 1'b0;
        exp_be = be; exp_wdata = byt ? {4{wd[7:0]}} : wd;
        if (wr) begin
            n = LAT + 1; exp_req_last = n; exp_we = 1'b1;
        end else if (mh) begin
            n = 0; exp_req_last = 0; exp_rd = 1'b1;
            exp_rdata = extract(m_data[ix], byt, addr[1:0]);
        end else begin
            d = mem_peek(aa);
            n = LAT + 2; exp_req_last = n - 1; exp_rd = 1'b1;
            exp_rdata = extract(d, byt, addr[1:0]);
        end
        exp_n = n; stall_seen = 0; req_seen = 0;
        for (int c = 0; c <= n; c++) begin
            if (c > 0) @(negedge clk);
            cpu_read = rd; cpu_write = wr; cpu_byte = byt;
            cpu_addr = addr; cpu_wdata = wd;
            cur_cyc = c; op_active = 1'b1;
        end
        @(negedge clk);
        cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte = 1'b0;
        op_active = 1'b0;
        if (wr) begin
            if (mh)
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_data[ix][8*b +: 8] = exp_wdata[8*b +: 8];
        end else if (!mh) begin
            m_valid[ix] = 1'b1; m_tag[ix] = addr[31:8]; m_data[ix] = d;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = 24'h0; m_data[i] = 32'h0;
        end
        bmem[32'h40]   = 32'hDEAD_BEEF;
        bmem[32'h140]  = 32'h0123_4567;
        bmem[32'h1000] = 32'hCAFE_F00D;
        rst_b = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_byte = 1'b0;
        cpu_addr = 32'h0; cpu_wdata = 32'h0;
        stall_seen = 0; req_seen = 0; cur_cyc = 0; exp_n = 0; exp_req_last = 0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_req", 32'(mif.mem_req), 32'd0);
        chk("rst_mem_we", 32'(mif.mem_we), 32'd0);
        chk("rst_mem_addr", mif.mem_addr, 32'd0);
        chk("rst_mem_wdata", mif.mem_wdata, 32'd0);
        chk("rst_mem_be", 32'(mif.mem_be), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst_b = 1'b1;
        chk_en = 1'b1;

        // Cold read miss and refill
        do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        chk("lw40_stalls", 32'(stall_seen), 32'd5);
        chk("lw40_reqs", 32'(req_seen), 32'd1);
        chk("lw40_addr", last_addr, 32'h40);
        chk("lw40_we", 32'(last_we), 32'd0);
        chk("lw40_data", last_rdata, 32'hDEAD_BEEF);

        // Hits: word and negative byte
        do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        chk("lw40_hit_stalls", 32'(stall_seen), 32'd0);
        chk("lw40_hit_reqs", 32'(req_seen), 32'd0);
        do_op(1'b1, 1'b0, 1'b1, 32'h43, 32'h0);
        chk("lb43_data", last_rdata, 32'hFFFF_FFDE);

        // Byte store into resident line
        do_op(1'b0, 1'b1, 1'b1, 32'h41, 32'h0000_005A);
        chk("sb41_be", 32'(last_be), 32'h2);
        chk("sb41_wdata", last_wdata, 32'h5A5A_5A5A);
        chk("sb41_stalls", 32'(stall_seen), 32'd4);
        do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        chk("lw40_merged", last_rdata, 32'hDEAD_5AEF);

        // Store miss does not allocate
        do_op(1'b0, 1'b1, 1'b0, 32'h1000, 32'h1122_3344);
        chk("sw1000_we", 32'(last_we), 32'd1);
        do_op(1'b1, 1'b0, 1'b0, 32'h1000, 32'h0);
        chk("lw1000_stalls", 32'(stall_seen), 32'd5);
        chk("lw1000_data", last_rdata, 32'h1122_3344);

        // Conflict eviction on the same index
        do_op(1'b1, 1'b0, 1'b0, 32'h140, 32'h0);
        chk("lw140_data", last_rdata, 32'h0123_4567);
        do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        chk("lw40_refetch_stalls", 32'(stall_seen), 32'd5);
        chk("lw40_refetch_data", last_rdata, 32'hDEAD_5AEF);

        // Read+write together is a write; positive and negative byte loads
        do_op(1'b1, 1'b1, 1'b0, 32'h40, 32'hA0B0_C0D0);
        do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        chk("rw_data", last_rdata, 32'hA0B0_C0D0);
        do_op(1'b1, 1'b0, 1'b1, 32'h40, 32'h0);
        chk("lb40_data", last_rdata, 32'hFFFF_FFD0);
        do_op(1'b0, 1'b1, 1'b1, 32'h42, 32'h0000_0012);
        chk("sb42_be", 32'(last_be), 32'h4);
        do_op(1'b1, 1'b0, 1'b1, 32'h42, 32'h0);
        chk("lb42_data", last_rdata, 32'h0000_0012);

        // Reset in the middle of a fill
        chk_en = 1'b0;
        @(negedge clk);
        cpu_read = 1'b1; cpu_addr = 32'h140;
        repeat (2) @(negedge clk);
        chk("pre_rst_req", 32'(mif.mem_req), 32'd1);
        rst_b = 1'b0;
        #1;
        chk("mid_rst_req", 32'(mif.mem_req), 32'd0);
        cpu_read = 1'b0;
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        chk_en = 1'b1;
        @(posedge clk);
        #1 force_ready = 1'b1;
        @(posedge clk);
        #1 force_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_op(1'b1, 1'b0, 1'b0, 32'h40, 32'h0);
        chk("post_rst_stalls", 32'(stall_seen), 32'd5);
        chk("post_rst_data", last_rdata, 32'hA012_C0D0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-through, no-write-allocate data cache controller for the MEM stage.
- Receives LW/LB/SW/SB requests from the pipeline and drives the `hit` and `stall` signals that the control unit consumes.
- Acts as initiator toward a multi-cycle backing memory using a req/ready handshake.
- One word per line; byte access via lane select.

Parameters:
- INDEX_W, 6, index bits; 2^INDEX_W lines.
- ADDR_W, 32, byte address width; tag = ADDR_W-INDEX_W-2 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- cpu_read  in  1  MEM-stage load (LW/LB).
- cpu_write  in  1  MEM-stage store (SW/SB).
- cpu_byte  in  1  byte access (LB/SB); 0 = word.
- cpu_addr  in  ADDR_W  byte address.
- cpu_wdata  in  32  store data; SB uses bits [7:0].
- cpu_rdata  out  32  load data (combinational).
- hit  out  1  lookup hit (combinational).
- stall  out  1  freeze pipeline (combinational).
- mem_req  out  1  backing-memory request, registered.
- mem_we  out  1  1 = write request, registered.
- mem_addr  out  ADDR_W  word-aligned address, registered.
- mem_wdata  out  32  write data, registered.
- mem_be  out  4  byte enables, registered.
- mem_rdata  in  32  fill data, valid while mem_ready=1.
- mem_ready  in  1  one-cycle completion pulse.

Behaviour:
- Reset (rst_b=0, async): all valid bits 0; state IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be = 0. Data and tag arrays are not cleared. Reset mid-FILL/WRITE aborts the transfer; mem_req drops immediately; any late mem_ready is ignored in IDLE.
- Address split: index = cpu_addr[INDEX_W+1:2], tag = upper bits, lane = cpu_addr[1:0]. Word access ignores lane.
- hit = valid[index] & (tag_arr[index]==tag) & (cpu_read|cpu_write).
- Load data:
  - Word: the line.
  - Byte: the selected little-endian lane, sign-extended to 32 bits.
- Simultaneous cpu_read and cpu_write: treated as write.
- IDLE:
  - Read hit: stall=0; data returned the same cycle (0-cycle hit).
  - Read miss: stall=1. Next edge: state FILL, mem_req=1, mem_we=0, mem_addr={addr[ADDR_W-1:2],2'b00}.
  - Write (hit or miss): stall=1. Next edge: state WRITE, mem_req=1, mem_we=1, mem_be = 4'b1111 (word) or one-hot lane (byte). mem_wdata = cpu_wdata (word) or the byte replicated to all lanes.
- FILL:
  - stall=1.
  - On mem_ready: write mem_rdata into the line, set tag and valid, deassert mem_req, go to IDLE.
  - The following cycle, the re-lookup hits and stall drops. Read-miss latency = memory latency + 2 cycles.
- WRITE:
  - stall = ~mem_ready, so the store retires in the mem_ready cycle.
  - On mem_ready: if the line hits, merge store data into it by byte enables (no-allocate on miss); deassert mem_req; go to IDLE.
- mem_req stays high and mem_addr/mem_we/mem_wdata/mem_be stay stable until mem_ready. Only one outstanding request.
- No request (read=write=0): stall=0, hit=0, cpu_rdata = line at index (don't-care).

Optional Feature:
- Macro: DCACHE_STATS_EN.
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0], reset to 0.
  - stat_hits increments once per retired read hit (IDLE, read, hit).
  - stat_misses increments once per FILL entry.
  - Both counters wrap at 2^32.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset then LW 0x0000_0040 (mem latency 3, mem_rdata=0xDEADBEEF) -> stall=1 for 5 cycles, one mem_req with addr 0x40 and mem_we=0, then hit=1, cpu_rdata=0xDEADBEEF, stall=0.
- Repeat LW 0x40 -> hit=1, stall=0 same cycle, no mem_req. LB 0x43 -> cpu_rdata=0xFFFFFFDE.
- SB 0x41 data 0x5A on a resident line -> mem_be=4'b0010, mem_wdata=0x5A5A5A5A, stall released in the mem_ready cycle. Then LW 0x40 hits with 0xDEAD5AEF.
- SW to miss address 0x1000 -> memory write issued; LW 0x1000 afterwards misses (no allocate).
- Conflict: LW 0x40 then LW 0x140 (INDEX_W=6, same index) -> second misses and refills; LW 0x40 then misses again.
- Assert rst_b=0 during FILL -> mem_req=0 immediately, valid cleared, a mem_ready after reset is ignored, next LW 0x40 misses.
